// File: rtl/polar_encoder.sv
// polar_encoder: converts a signed Cartesian displacement (x, y) into the packed
// r_theta word {sector code[3:0], magnitude[7:0]}. The design takes one cycle to
// square the inputs and classify the sector, then 12 cycles for a bit-serial
// restoring square root, then one cycle to register the result.
module polar_encoder #(
  parameter int TAN30_Q8 = 148,
  parameter int TAN60_Q8 = 443
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  output logic        busy,
  output logic        valid,
  output logic [11:0] r_theta,
  output logic        saturated,
  output logic        out_of_range
);

  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

  state_t state_reg, state_next;

  logic [11:0] x_reg, y_reg;
  logic [23:0] sum_reg;     // radicand, shifted left two bits per root step
  logic [13:0] rem_reg;     // partial remainder of the restoring root
  logic [11:0] root_reg;    // partial root, one bit appended per step
  logic [3:0]  count_reg;
  logic        neg_x_reg, neg_y_reg, lo_reg, hi_reg, zero_reg;

  // Magnitudes and squares of the registered operands (|-2048| = 2048 needs 13 bits)
  logic [12:0] ax, ay;
  logic [23:0] sq_x, sq_y, sum;
  logic [20:0] y_scaled, x_tan30, x_tan60;
  logic        lo, hi;

  // Root iteration datapath
  logic [15:0] rem_shift, trial;
  logic        take;

  // Sector code and saturated magnitude assembled from the latched flags
  logic [1:0]  band;
  logic [3:0]  code;
  logic [7:0]  mag;

  // Square, magnitude and sector boundary compares for the SQUARE cycle
  always_comb begin
    ax       = x_reg[11] ? (~{x_reg[11], x_reg} + 13'd1) : {1'b0, x_reg};
    ay       = y_reg[11] ? (~{y_reg[11], y_reg} + 13'd1) : {1'b0, y_reg};
    sq_x     = {11'd0, ax} * {11'd0, ax};
    sq_y     = {11'd0, ay} * {11'd0, ay};
    sum      = sq_x + sq_y;
    y_scaled = {ay, 8'd0};
    x_tan30  = 21'(TAN30_Q8) * {8'd0, ax};
    x_tan60  = 21'(TAN60_Q8) * {8'd0, ax};
    lo       = (y_scaled <  x_tan30);
    hi       = (y_scaled >= x_tan60);
  end

  // One restoring square-root step: bring down two radicand bits, try root*4+1
  always_comb begin
    rem_shift = {rem_reg, sum_reg[23:22]};
    trial     = {2'b00, root_reg, 2'b01};
    take      = (rem_shift >= trial);
  end

  // Sector code: boundary equality lands in the higher-angle band
  always_comb begin
    band = hi ? 2'd2 : 2'd0;
    band = hi_reg ? 2'd2 : (lo_reg ? 2'd0 : 2'd1);
    if (neg_y_reg)
      code = 4'd0;
    else if (zero_reg)
      code = 4'd1;
    else if (neg_x_reg)
      code = 4'd6 - {2'b00, band};
    else
      code = {2'b00, band} + 4'd1;
    mag = (root_reg[11:8] != 4'd0) ? 8'hFF : root_reg[7:0];
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic; start is only honoured in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SQUARE;
      SQUARE:  state_next = ROOT;
      ROOT:    if (count_reg == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    busy = (state_reg != IDLE);
  end

  // Datapath registers and result outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_reg        <= '0;
      y_reg        <= '0;
      sum_reg      <= '0;
      rem_reg      <= '0;
      root_reg     <= '0;
      count_reg    <= '0;
      neg_x_reg    <= 1'b0;
      neg_y_reg    <= 1'b0;
      lo_reg       <= 1'b0;
      hi_reg       <= 1'b0;
      zero_reg     <= 1'b0;
      valid        <= 1'b0;
      r_theta      <= '0;
      saturated    <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      valid <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg <= x_in;
            y_reg <= y_in;
          end
        end
        SQUARE: begin
          sum_reg   <= sum;
          rem_reg   <= '0;
          root_reg  <= '0;
          count_reg <= 4'd11;
          neg_x_reg <= x_reg[11];
          neg_y_reg <= y_reg[11];
          lo_reg    <= lo;
          hi_reg    <= hi;
          zero_reg  <= (x_reg == 12'd0) && (y_reg == 12'd0);
        end
        ROOT: begin
          sum_reg   <= {sum_reg[21:0], 2'b00};
          rem_reg   <= take ? 14'(rem_shift - trial) : 14'(rem_shift);
          root_reg  <= {root_reg[10:0], take};
          count_reg <= count_reg - 4'd1;
        end
        DONE: begin
          r_theta      <= {code, mag};
          saturated    <= (root_reg[11:8] != 4'd0);
          out_of_range <= neg_y_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
